// File: rtl/reaction_array.sv
// Multi-channel reaction timer: a stimulus pulse starts every channel counting,
// and each responder's trigger freezes its own count. Tracks the fastest valid stop.
//
// state  | meaning
// IDLE   | waiting for time_out; early triggers latch false_start
// RUN    | counting channels increment each tick until their trigger
// DONE   | all channels stopped; results held until next time_out or clear
module reaction_array #(
  parameter int WIDTH    = 15,
  parameter int CHANNELS = 4,
  parameter int SAT      = 1
) (
  input  logic                      tick_ms,
  input  logic                      reset,
  input  logic                      time_out,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic                      clear,
  output logic [CHANNELS*WIDTH-1:0] reaction_time,
  output logic [CHANNELS-1:0]       done,
  output logic [CHANNELS-1:0]       false_start,
  output logic [CHANNELS-1:0]       overflow,
  output logic                      busy,
  output logic [WIDTH-1:0]          best_time,
  output logic [3:0]                best_ch,
  output logic                      best_valid
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t               state, state_n;
  logic [WIDTH-1:0]     cnt_q [CHANNELS];
  logic [WIDTH-1:0]     cnt_n [CHANNELS];
  logic [CHANNELS-1:0]  done_q, done_n;
  logic [CHANNELS-1:0]  fs_q, fs_n;
  logic [CHANNELS-1:0]  ov_q, ov_n;
  logic [CHANNELS-1:0]  counting_q, counting_n;
  logic [WIDTH-1:0]     bt_q, bt_n;
  logic [3:0]           bc_q, bc_n;
  logic                 bv_q, bv_n;
  logic                 busy_q, busy_n;

  always_ff @(posedge tick_ms or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= '0;
      done_q     <= '0;
      fs_q       <= '0;
      ov_q       <= '0;
      counting_q <= '0;
      bt_q       <= '1;
      bc_q       <= '0;
      bv_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_n;
      for (int i = 0; i < CHANNELS; i++) cnt_q[i] <= cnt_n[i];
      done_q     <= done_n;
      fs_q       <= fs_n;
      ov_q       <= ov_n;
      counting_q <= counting_n;
      bt_q       <= bt_n;
      bc_q       <= bc_n;
      bv_q       <= bv_n;
      busy_q     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    for (int i = 0; i < CHANNELS; i++) cnt_n[i] = cnt_q[i];
    done_n     = done_q;
    fs_n       = fs_q;
    ov_n       = ov_q;
    counting_n = counting_q;
    bt_n       = bt_q;
    bc_n       = bc_q;
    bv_n       = bv_q;

    if (clear) begin
      state_n    = S_IDLE;
      for (int i = 0; i < CHANNELS; i++) cnt_n[i] = '0;
      done_n     = '0;
      fs_n       = '0;
      ov_n       = '0;
      counting_n = '0;
      bt_n       = '1;
      bc_n       = '0;
      bv_n       = 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (time_out) begin
            // false-started channels begin the run already stopped
            state_n    = S_RUN;
            for (int i = 0; i < CHANNELS; i++) cnt_n[i] = '0;
            ov_n       = '0;
            done_n     = fs_q;
            counting_n = ~fs_q;
          end else if (state == S_IDLE) begin
            fs_n = fs_q | trigger;
          end
        end
        S_RUN: begin
          // ascending scan with strict compare: lowest index wins ties
          for (int i = 0; i < CHANNELS; i++) begin
            if (counting_q[i]) begin
              if (trigger[i]) begin
                counting_n[i] = 1'b0;
                done_n[i]     = 1'b1;
                if (!ov_q[i] && (!bv_n || cnt_q[i] < bt_n)) begin
                  bt_n = cnt_q[i];
                  bc_n = 4'(i);
                  bv_n = 1'b1;
                end
              end else if (cnt_q[i] == CNT_MAX) begin
                ov_n[i] = 1'b1;
                if (SAT == 0) cnt_n[i] = '0;
              end else begin
                cnt_n[i] = cnt_q[i] + CNT_ONE;
                if (cnt_q[i] == CNT_MAX - CNT_ONE) ov_n[i] = 1'b1;
              end
            end
          end
          if (&done_q) state_n = S_DONE;
        end
        default: state_n = S_IDLE;
      endcase
    end

    busy_n = (state_n == S_RUN);
  end

  always_comb begin
    reaction_time = '0;
    for (int i = 0; i < CHANNELS; i++) reaction_time[i*WIDTH +: WIDTH] = cnt_q[i];
  end

  assign done        = done_q;
  assign false_start = fs_q;
  assign overflow    = ov_q;
  assign busy        = busy_q;
  assign best_time   = bt_q;
  assign best_ch     = bc_q;
  assign best_valid  = bv_q;

endmodule

// File: tb/tb_reaction_array.sv
// Directed bench for reaction_array: default instance plus two WIDTH=4 instances
// (saturating and wrapping) for the counter-limit cases.
module tb_reaction_array;

  logic        tick_ms = 1'b0;
  logic        reset, time_out, clear;
  logic [3:0]  trigger;
  logic [59:0] rt_bus;
  logic [3:0]  done, false_start, overflow;
  logic        busy, best_valid;
  logic [14:0] best_time;
  logic [3:0]  best_ch;

  logic        s_time_out, s_clear;
  logic [3:0]  s_trigger;
  logic [15:0] sa_rt, wr_rt;
  logic [3:0]  sa_done, sa_fs, sa_ov, wr_done, wr_fs, wr_ov;
  logic        sa_busy, sa_bv, wr_busy, wr_bv;
  logic [3:0]  sa_bt, wr_bt, sa_bc, wr_bc;

  int vectors = 0;
  int errors  = 0;

  always #5 tick_ms = ~tick_ms;

  reaction_array u_dut (
    .tick_ms(tick_ms), .reset(reset), .time_out(time_out), .trigger(trigger), .clear(clear),
    .reaction_time(rt_bus), .done(done), .false_start(false_start), .overflow(overflow),
    .busy(busy), .best_time(best_time), .best_ch(best_ch), .best_valid(best_valid));

  reaction_array #(.WIDTH(4), .CHANNELS(4), .SAT(1)) u_sat (
    .tick_ms(tick_ms), .reset(reset), .time_out(s_time_out), .trigger(s_trigger), .clear(s_clear),
    .reaction_time(sa_rt), .done(sa_done), .false_start(sa_fs), .overflow(sa_ov),
    .busy(sa_busy), .best_time(sa_bt), .best_ch(sa_bc), .best_valid(sa_bv));

  reaction_array #(.WIDTH(4), .CHANNELS(4), .SAT(0)) u_wrap (
    .tick_ms(tick_ms), .reset(reset), .time_out(s_time_out), .trigger(s_trigger), .clear(s_clear),
    .reaction_time(wr_rt), .done(wr_done), .false_start(wr_fs), .overflow(wr_ov),
    .busy(wr_busy), .best_time(wr_bt), .best_ch(wr_bc), .best_valid(wr_bv));

  function automatic logic [14:0] rt(int i);
    return rt_bus[i*15 +: 15];
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n rising edges, then settle 1 time unit past the last one
  task automatic cyc(int n);
    repeat (n) @(posedge tick_ms);
    #1;
  endtask

  initial begin
    reset = 1'b1; time_out = 1'b0; clear = 1'b0; trigger = '0;
    s_time_out = 1'b0; s_clear = 1'b0; s_trigger = '0;
    #12;
    chk("rst_rt",    rt_bus,     0);
    chk("rst_done",  done,       0);
    chk("rst_busy",  busy,       0);
    chk("rst_bt",    best_time,  15'h7fff);
    chk("rst_bv",    best_valid, 0);
    @(posedge tick_ms); #1;
    reset = 1'b0;

    // run 1: start at edge 0, ch2 at edge 37, ch0 at edge 50, ch1/ch3 at edge 51
    time_out = 1'b1; cyc(1); time_out = 1'b0;
    chk("r1_busy_start", busy, 1);
    chk("r1_rt_start",   rt_bus, 0);
    cyc(36);
    time_out = 1'b1; trigger = 4'b0100; cyc(1); trigger = '0; time_out = 1'b0;
    chk("r1_rt2",   rt(2), 36);
    chk("r1_done2", done,  4'b0100);
    cyc(12);
    trigger = 4'b0001; cyc(1); trigger = '0;
    chk("r1_rt0",  rt(0),     49);
    chk("r1_bc",   best_ch,   2);
    chk("r1_bt",   best_time, 36);
    trigger = 4'b1010; cyc(1); trigger = '0;
    chk("r1_busy_lastcycle", busy, 1);
    trigger = 4'b0101; cyc(1); trigger = '0;
    chk("r1_busy_end", busy, 0);
    chk("r1_done",     done, 4'hf);
    chk("r1_rt1",      rt(1), 50);
    chk("r1_rt2_held", rt(2), 36);
    chk("r1_bv",       best_valid, 1);

    // run 2: slower, all stop at 40
    time_out = 1'b1; cyc(1); time_out = 1'b0;
    cyc(40);
    trigger = 4'hf; cyc(1); trigger = '0; cyc(1);
    chk("r2_rt3", rt(3), 40);
    chk("r2_bt",  best_time, 36);
    chk("r2_bc",  best_ch, 2);

    // run 3: faster, all stop at 10 -> lowest index takes it
    time_out = 1'b1; cyc(1); time_out = 1'b0;
    cyc(10);
    trigger = 4'hf; cyc(1); trigger = '0; cyc(1);
    chk("r3_bt", best_time, 10);
    chk("r3_bc", best_ch, 0);

    // clear wins over time_out
    clear = 1'b1; time_out = 1'b1; cyc(1); clear = 1'b0; time_out = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_bv",   best_valid, 0);
    chk("clr_bt",   best_time, 15'h7fff);
    chk("clr_done", done, 0);
    chk("clr_rt",   rt_bus, 0);

    // false start on ch1, then ch0/ch3 simultaneous at 20
    trigger = 4'b0010; cyc(1); trigger = '0;
    chk("fs_flag", false_start, 4'b0010);
    time_out = 1'b1; cyc(1); time_out = 1'b0;
    chk("fs_done_start", done, 4'b0010);
    cyc(20);
    trigger = 4'b1001; cyc(1); trigger = '0;
    chk("sim_bc", best_ch, 0);
    chk("sim_bt", best_time, 20);
    trigger = 4'b0100; cyc(1); trigger = '0; cyc(1);
    chk("fs_rt1",    rt(1), 0);
    chk("fs_busy",   busy, 0);
    chk("fs_sticky", false_start, 4'b0010);
    chk("fs_bt",     best_time, 20);

    // equal count does not replace existing best
    time_out = 1'b1; cyc(1); time_out = 1'b0;
    cyc(20);
    trigger = 4'b1000; cyc(1); trigger = '0;
    chk("eq_rt3", rt(3), 20);
    chk("eq_bc",  best_ch, 0);
    trigger = 4'b0101; cyc(1); trigger = '0; cyc(1);

    // all channels false-started: one RUN cycle
    clear = 1'b1; cyc(1); clear = 1'b0;
    trigger = 4'hf; cyc(1); trigger = '0;
    time_out = 1'b1; cyc(1); time_out = 1'b0;
    chk("afs_busy1", busy, 1);
    cyc(1);
    chk("afs_busy2", busy, 0);
    chk("afs_bv",    best_valid, 0);

    // async reset mid-run
    clear = 1'b1; cyc(1); clear = 1'b0;
    time_out = 1'b1; cyc(1); time_out = 1'b0;
    cyc(5);
    reset = 1'b1; #2;
    chk("arst_busy", busy, 0);
    chk("arst_rt",   rt_bus, 0);
    chk("arst_done", done, 0);
    reset = 1'b0;
    cyc(3);
    chk("arst_idle", busy, 0);
    chk("arst_rt2",  rt_bus, 0);

    // WIDTH=4: 20 edges without trigger
    s_time_out = 1'b1; cyc(1); s_time_out = 1'b0;
    cyc(20);
    s_trigger = 4'hf; cyc(1); s_trigger = '0;
    chk("sat_rt",  sa_rt[3:0], 15);
    chk("sat_ov",  sa_ov, 4'hf);
    chk("sat_bv",  sa_bv, 0);
    chk("wrap_rt", wr_rt[3:0], 4);
    chk("wrap_ov", wr_ov, 4'hf);
    chk("wrap_bv", wr_bv, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/reaction_array.md
REACTION_ARRAY -- requirements
Module: reaction_array

Interface
REQ-001 SHALL have parameter WIDTH, default 15: reaction counter width in bits.
REQ-002 SHALL have parameter CHANNELS, default 4: number of independent responders, range 1..16.
REQ-003 SHALL have parameter SAT, default 1: 1 = counter saturates at 2^WIDTH-1, 0 = counter wraps to 0.
REQ-004 SHALL have port tick_ms, input, 1: single clock; all state updates on posedge; one count per edge.
REQ-005 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port time_out, input, 1: stimulus pulse; starts a run.
REQ-007 SHALL have port trigger, input, CHANNELS: per-channel responder input, level-sampled on posedge.
REQ-008 SHALL have port clear, input, 1: synchronous abort of the run and clear of session results.
REQ-009 SHALL have port reaction_time, output, CHANNELS*WIDTH: channel i count in bits [i*WIDTH +: WIDTH].
REQ-010 SHALL have port done, output, CHANNELS: channel i has stopped in the current or last run.
REQ-011 SHALL have port false_start, output, CHANNELS: channel i triggered before the stimulus.
REQ-012 SHALL have port overflow, output, CHANNELS: channel i counter reached or passed 2^WIDTH-1 in this run.
REQ-013 SHALL have port busy, output, 1: high while in RUN.
REQ-014 SHALL have port best_time, output, WIDTH: lowest valid reaction this session.
REQ-015 SHALL have port best_ch, output, 4: index of the channel holding best_time.
REQ-016 SHALL have port best_valid, output, 1: best_time/best_ch hold a result.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DONE.
REQ-018 IDLE->RUN SHALL occur on time_out=1. In that edge: counters go to 0, overflow goes to 0, done[i] goes to false_start[i], and counting[i] goes to !false_start[i].
REQ-019 In IDLE, trigger[i]=1 with time_out=0 SHALL set false_start[i]. The flag is sticky until clear or reset.
REQ-020 When time_out and trigger[i] are both 1 in IDLE, time_out SHALL win and false_start[i] SHALL not be set.
REQ-021 In RUN, each edge a counting channel with trigger[i]=0 SHALL increment by 1. The first count appears 1 edge after the start edge.
REQ-022 In RUN, trigger[i]=1 on a counting channel SHALL stop it without increment, set done[i], and freeze reaction_time[i].
REQ-023 SAT=1: a counter at 2^WIDTH-1 SHALL hold and set overflow[i]. SAT=0: it SHALL wrap to 0 and set overflow[i].
REQ-024 RUN->DONE SHALL occur on the edge after all done bits are 1. A run with every channel false-started SHALL go to DONE after 1 RUN cycle.
REQ-025 A stopping channel with overflow[i]=0 and (best_valid=0 or count < best_time) SHALL load best_time/best_ch and set best_valid.
REQ-026 For simultaneous qualifying stops, the lowest channel index SHALL win. An equal count to the existing best SHALL not replace it.
REQ-027 DONE SHALL hold all outputs. time_out in DONE SHALL start a new run per REQ-018. best_* and false_start SHALL persist.
REQ-028 time_out in RUN SHALL be ignored. trigger on a stopped channel SHALL be ignored.
REQ-029 clear=1 SHALL return to IDLE and zero counters, done, overflow, false_start and best_valid, from any state. best_time SHALL go to all-ones and best_ch to 0.
REQ-030 clear SHALL take priority over time_out in the same edge.
REQ-031 busy SHALL be registered and equal to (state==RUN).

Reset
REQ-032 reset=1 SHALL immediately force IDLE, reaction_time=0, done=0, false_start=0, overflow=0, busy=0, best_time=all-ones, best_ch=0, best_valid=0, independent of tick_ms.
REQ-033 Deasserting reset mid-run SHALL leave the block in IDLE awaiting time_out. No run resumes.

Verification
REQ-034 Defaults; time_out at edge 0, trigger[2] at edge 37, trigger[0] at edge 50, then triggers 1 and 3 SHALL give rt[2]=36, rt[0]=49, best_ch=2, best_time=36, busy low after all done.
REQ-035 trigger[1] in IDLE, then time_out SHALL give false_start[1]=1, done[1]=1, rt[1]=0, and channel 1 excluded from best.
REQ-036 trigger[0] and trigger[3] at the same edge with count 20 SHALL give best_ch=0, best_time=20.
REQ-037 WIDTH=4 with no trigger for 20 edges SHALL give: SAT=1 rt=15, overflow=1; SAT=0 rt=4, overflow=1; neither updates best.
REQ-038 reset asserted between edges mid-run SHALL clear outputs before the next edge. clear with time_out at the same edge SHALL leave state IDLE.
REQ-039 A second run with slower times SHALL leave best_time unchanged. A faster run SHALL replace it.
